// File: rtl/riscv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : riscv_pkg                                          |
// | Description : Shared types and encodings for the memory stage:  |
// |               access FSM states, Funct3 load/store codes and     |
// |               ResultSrc selects.                                 |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
package riscv_pkg;

    // Memory-access sequencer states
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_t;

    // Funct3 encodings for loads
    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    // Funct3 encodings for stores
    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;

    // ResultSrc encodings
    localparam logic [1:0] c_RES_ALU = 2'b00;
    localparam logic [1:0] c_RES_MEM = 2'b01;
    localparam logic [1:0] c_RES_PC4 = 2'b10;

endpackage
`default_nettype wire

// File: rtl/memory_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : memory_stage_if                                    |
// | Description : Data-memory request/response bus between the M     |
// |               stage (master) and the data memory (slave).        |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
interface memory_stage_if;
    import riscv_pkg::*;

    logic        DMemReq;
    logic        DMemWe;
    logic [31:0] DMemAddr;
    logic [31:0] DMemWData;
    logic [3:0]  DMemBe;
    logic [31:0] DMemRData;
    logic        DMemReady;

    modport master (
        output DMemReq, DMemWe, DMemAddr, DMemWData, DMemBe,
        input  DMemRData, DMemReady
    );

    modport slave (
        input  DMemReq, DMemWe, DMemAddr, DMemWData, DMemBe,
        output DMemRData, DMemReady
    );

endinterface
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : load_store_align                                   |
// | Description : Combinational byte-lane formatting: store lane     |
// |               replication and byte enables, load lane select     |
// |               with sign/zero extension, and access legality.     |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module load_store_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_is_store,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_load_data,
    output logic        o_bad
);

    logic [31:0] w_lane;

    // Bring the addressed byte down to lane 0 for loads
    assign w_lane = i_rdata >> {i_addr_lo, 3'b000};

    // Decode width/sign; unsupported codes and misaligned addresses are flagged bad
    always_comb begin
        o_wdata     = i_store_data;
        o_be        = 4'b0000;
        o_load_data = 32'h0;
        o_bad       = 1'b0;
        if (i_is_store) begin
            case (i_funct3)
                c_F3_SB: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_store_data[7:0]}};
                end
                c_F3_SH: begin
                    o_be    = 4'b0011 << i_addr_lo;
                    o_wdata = {2{i_store_data[15:0]}};
                    o_bad   = i_addr_lo[0];
                end
                c_F3_SW: begin
                    o_be    = 4'b1111 << i_addr_lo;
                    o_wdata = i_store_data;
                    o_bad   = |i_addr_lo;
                end
                default: o_bad = 1'b1;
            endcase
        end else begin
            case (i_funct3)
                c_F3_LB:  o_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
                c_F3_LBU: o_load_data = {24'h0, w_lane[7:0]};
                c_F3_LH: begin
                    o_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
                    o_bad       = i_addr_lo[0];
                end
                c_F3_LHU: begin
                    o_load_data = {16'h0, w_lane[15:0]};
                    o_bad       = i_addr_lo[0];
                end
                c_F3_LW: begin
                    o_load_data = w_lane;
                    o_bad       = |i_addr_lo;
                end
                default: o_bad = 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : memory_stage                                       |
// | Description : Pipeline M stage: EX/MEM register, data-memory     |
// |               request sequencer with stall generation, and       |
// |               load/store lane formatting.                        |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module memory_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic [1:0]  ResultSrcE,
    input  logic [4:0]  RdE,
    input  logic [2:0]  Funct3E,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [31:0] PCPlus4E,
    output logic        RegWriteM,
    output logic [1:0]  ResultSrcM,
    output logic [4:0]  RdM,
    output logic [31:0] ALUResultM,
    output logic [31:0] PCPlus4M,
    output logic [31:0] ReadDataM,
    output logic        BusyM,
    output logic        MisalignM,
    memory_stage_if.master dmem
);

    logic        r_regwrite;
    logic        r_memwrite;
    logic [1:0]  r_resultsrc;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic [31:0] r_aluresult;
    logic [31:0] r_writedata;
    logic [31:0] r_pcplus4;

    mem_state_t  r_state;
    mem_state_t  w_state_next;

    logic        w_memop;
    logic        w_is_load;
    logic        w_fmt_bad;
    logic        w_misalign;
    logic        w_req;
    logic        w_busy;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;
    logic [3:0]  w_be;

    // EX/MEM register: advance every cycle unless the current access stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regwrite  <= 1'b0;
            r_memwrite  <= 1'b0;
            r_resultsrc <= 2'b00;
            r_rd        <= 5'd0;
            r_funct3    <= 3'd0;
            r_aluresult <= 32'h0;
            r_writedata <= 32'h0;
            r_pcplus4   <= 32'h0;
        end else if (!w_busy) begin
            r_regwrite  <= RegWriteE;
            r_memwrite  <= MemWriteE;
            r_resultsrc <= ResultSrcE;
            r_rd        <= RdE;
            r_funct3    <= Funct3E;
            r_aluresult <= ALUResultE;
            r_writedata <= WriteDataE;
            r_pcplus4   <= PCPlus4E;
        end
    end

    assign w_memop    = r_memwrite | (r_resultsrc == c_RES_MEM);
    assign w_is_load  = (r_resultsrc == c_RES_MEM) & ~r_memwrite;
    assign w_misalign = w_memop & w_fmt_bad;

    load_store_align u_align (
        .i_funct3     (r_funct3),
        .i_is_store   (r_memwrite),
        .i_addr_lo    (r_aluresult[1:0]),
        .i_store_data (r_writedata),
        .i_rdata      (dmem.DMemRData),
        .o_wdata      (w_wdata),
        .o_be         (w_be),
        .o_load_data  (w_load_data),
        .o_bad        (w_fmt_bad)
    );

    // Sequencer state register; reset abandons any outstanding access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Issue one request per memory op; stall until the memory signals ready
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_memop && !w_misalign) begin
                    w_req = 1'b1;
                    if (!dmem.DMemReady) begin
                        w_busy       = 1'b1;
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // EX/MEM is frozen here, so address/data/enables stay stable
                w_req  = 1'b1;
                w_busy = ~dmem.DMemReady;
                if (dmem.DMemReady) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign dmem.DMemReq   = w_req;
    assign dmem.DMemWe    = w_req & r_memwrite;
    assign dmem.DMemAddr  = {r_aluresult[31:2], 2'b00};
    assign dmem.DMemWData = w_wdata;
    assign dmem.DMemBe    = (w_req & r_memwrite) ? w_be : 4'b0000;

    assign RegWriteM  = r_regwrite & ~w_misalign;
    assign ResultSrcM = r_resultsrc;
    assign RdM        = r_rd;
    assign ALUResultM = r_aluresult;
    assign PCPlus4M   = r_pcplus4;
    assign BusyM      = w_busy;
    assign MisalignM  = w_misalign;
    assign ReadDataM  = (w_req && w_is_load && dmem.DMemReady) ? w_load_data : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_memory_stage                                    |
// | Description : Self-checking bench for memory_stage: directed     |
// |               scenarios plus randomized traffic compared against |
// |               an instruction-level reference model.              |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module tb_memory_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE;
    logic [1:0]  ResultSrcE;
    logic [4:0]  RdE;
    logic [2:0]  Funct3E;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, PCPlus4M, ReadDataM;
    logic        BusyM, MisalignM;

    memory_stage_if dmem();

    memory_stage dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .ResultSrcE (ResultSrcE),
        .RdE        (RdE),
        .Funct3E    (Funct3E),
        .ALUResultE (ALUResultE),
        .WriteDataE (WriteDataE),
        .PCPlus4E   (PCPlus4E),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .RdM        (RdM),
        .ALUResultM (ALUResultM),
        .PCPlus4M   (PCPlus4M),
        .ReadDataM  (ReadDataM),
        .BusyM      (BusyM),
        .MisalignM  (MisalignM),
        .dmem       (dmem)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        regwrite;
        logic        memwrite;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
    } instr_t;

    instr_t m;
    logic   m_busy = 1'b0;

    function automatic int unsigned acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit legal(input bit st, input logic [2:0] f3);
        if (st) return (f3 <= 3'd2);
        return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    // The instruction in M advances whenever the previous cycle was not a stall
    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else if (!m_busy)
            m <= {RegWriteE, MemWriteE, ResultSrcE, RdE, Funct3E, ALUResultE, WriteDataE, PCPlus4E};
    end

    // Compare every DUT output against the model once per cycle
    always @(negedge clk) begin
        bit st, ld, memop, mis, req, busy;
        int unsigned sz, off;
        logic [31:0] e_be, e_wd, e_rd, v;
        st    = m.memwrite;
        ld    = (m.rs == 2'b01) && !m.memwrite;
        memop = m.memwrite || (m.rs == 2'b01);
        sz    = acc_size(m.f3);
        off   = m.alu % 4;
        mis   = memop && !(legal(st, m.f3) && ((m.alu % sz) == 0));
        req   = memop && !mis;
        busy  = req && !dmem.DMemReady;
        e_be  = (req && st) ? ((((32'd1 << sz) - 1) << off) & 32'hF) : 32'h0;
        if (sz == 1)      e_wd = m.wd[7:0] * 32'h01010101;
        else if (sz == 2) e_wd = m.wd[15:0] * 32'h00010001;
        else              e_wd = m.wd;
        v = dmem.DMemRData >> (8 * off);
        if (sz < 4) begin
            v = v & ((32'd1 << (8 * sz)) - 1);
            if (!m.f3[2] && v[8*sz-1]) v = v - (32'd1 << (8 * sz));
        end
        e_rd = (req && ld && dmem.DMemReady) ? v : 32'h0;
        m_busy <= busy;
        if (chk_en) begin
            chk("cmp_regwrite",  32'(RegWriteM),     32'(m.regwrite && !mis));
            chk("cmp_resultsrc", 32'(ResultSrcM),    32'(m.rs));
            chk("cmp_rd",        32'(RdM),           32'(m.rd));
            chk("cmp_aluresult", ALUResultM,         m.alu);
            chk("cmp_pcplus4",   PCPlus4M,           m.pc4);
            chk("cmp_misalign",  32'(MisalignM),     32'(mis));
            chk("cmp_busy",      32'(BusyM),         32'(busy));
            chk("cmp_req",       32'(dmem.DMemReq),  32'(req));
            chk("cmp_we",        32'(dmem.DMemWe),   32'(req && st));
            chk("cmp_addr",      dmem.DMemAddr,      m.alu & 32'hFFFF_FFFC);
            chk("cmp_be",        32'(dmem.DMemBe),   e_be);
            chk("cmp_readdata",  ReadDataM,          e_rd);
            if (req && st) chk("cmp_wdata", dmem.DMemWData, e_wd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_e(input logic rw, input logic mw, input logic [1:0] rs, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pc4);
        RegWriteE = rw; MemWriteE = mw; ResultSrcE = rs; RdE = rd;
        Funct3E = f3; ALUResultE = alu; WriteDataE = wd; PCPlus4E = pc4;
    endtask

    task automatic nop_e();
        set_e(1'b0, 1'b0, 2'b00, 5'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        bit pend;
        int unsigned cnt;
        int unsigned kind;
        logic [31:0] alu;
        logic [2:0]  f3;

        rst = 1'b1;
        nop_e();
        dmem.DMemReady = 1'b0;
        dmem.DMemRData = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy",     32'(BusyM),        32'h0);
        chk("reset_req",      32'(dmem.DMemReq), 32'h0);
        chk("reset_regwrite", 32'(RegWriteM),    32'h0);
        chk("reset_aluresult", ALUResultM,       32'h0);
        chk_en = 1'b1;
        rst = 1'b0;

        // SW 0x100, ready in the same cycle
        set_e(1'b0, 1'b1, 2'b00, 5'd0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h4);
        step(); nop_e();
        dmem.DMemReady = 1'b1;
        #1;
        chk("sw_be",    32'(dmem.DMemBe),   32'hF);
        chk("sw_addr",  dmem.DMemAddr,      32'h100);
        chk("sw_wdata", dmem.DMemWData,     32'hDEADBEEF);
        chk("sw_req",   32'(dmem.DMemReq),  32'h1);
        chk("sw_busy",  32'(BusyM),         32'h0);
        step();
        dmem.DMemReady = 1'b0;
        #1;
        chk("sw_no_reissue", 32'(dmem.DMemReq), 32'h0);

        // LB / LBU from 0x103
        set_e(1'b1, 1'b0, 2'b01, 5'd5, 3'b000, 32'h103, 32'h0, 32'h8);
        step(); nop_e();
        dmem.DMemReady = 1'b1;
        dmem.DMemRData = 32'h80000000;
        #1;
        chk("lb_sext", ReadDataM, 32'hFFFFFF80);
        set_e(1'b1, 1'b0, 2'b01, 5'd6, 3'b100, 32'h103, 32'h0, 32'hC);
        step(); nop_e();
        #1;
        chk("lbu_zext", ReadDataM, 32'h00000080);

        // LW with three wait cycles; a younger op waits in E
        set_e(1'b1, 1'b0, 2'b01, 5'd9, 3'b010, 32'h40, 32'h0, 32'h10);
        step();
        set_e(1'b1, 1'b0, 2'b00, 5'd7, 3'b000, 32'h1234, 32'h0, 32'h50);
        dmem.DMemReady = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                dmem.DMemReady = 1'b1;
                dmem.DMemRData = 32'h11223344;
            end
            #1;
            if (BusyM) busy_cnt++;
            chk("lw_hold_req",  32'(dmem.DMemReq), 32'h1);
            chk("lw_hold_addr", dmem.DMemAddr,     32'h40);
            chk("lw_hold_alu",  ALUResultM,        32'h40);
            if (k == 3) chk("lw_data", ReadDataM, 32'h11223344);
            else        step();
        end
        chk("lw_busy_cycles", 32'(busy_cnt), 32'd3);
        step(); nop_e();
        dmem.DMemReady = 1'b0;
        #1;
        chk("lw_next_alu", ALUResultM,        32'h1234);
        chk("lw_next_rd",  32'(RdM),          32'd7);
        chk("lw_next_req", 32'(dmem.DMemReq), 32'h0);

        // SH to an odd address
        set_e(1'b1, 1'b1, 2'b00, 5'd3, 3'b001, 32'h101, 32'h1234, 32'h0);
        step();
        set_e(1'b1, 1'b0, 2'b00, 5'd4, 3'b000, 32'h55, 32'h0, 32'h0);
        #1;
        chk("sh_mis_flag",     32'(MisalignM),    32'h1);
        chk("sh_mis_req",      32'(dmem.DMemReq), 32'h0);
        chk("sh_mis_regwrite", 32'(RegWriteM),    32'h0);
        chk("sh_mis_busy",     32'(BusyM),        32'h0);
        step(); nop_e();
        #1;
        chk("sh_mis_advance", ALUResultM,       32'h55);
        chk("sh_mis_cleared", 32'(MisalignM),   32'h0);

        // Reset while waiting on a load
        set_e(1'b1, 1'b0, 2'b01, 5'd10, 3'b010, 32'h80, 32'h0, 32'h0);
        step(); nop_e();
        step();
        #1;
        chk("rst_pre_req", 32'(dmem.DMemReq), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_req_drop",   32'(dmem.DMemReq),  32'h0);
        chk("rst_busy_drop",  32'(BusyM),         32'h0);
        chk("rst_state_idle", 32'(dut.r_state),   32'(S_IDLE));
        chk("rst_alu_clear",  ALUResultM,         32'h0);
        step();
        rst = 1'b0;
        dmem.DMemReady = 1'b1;
        dmem.DMemRData = 32'hFFFFFFFF;
        #1;
        chk("rst_late_ready_data", ReadDataM,          32'h0);
        chk("rst_late_ready_req",  32'(dmem.DMemReq),  32'h0);
        step();
        dmem.DMemReady = 1'b0;
        #1;
        chk("rst_late_ready_rw", 32'(RegWriteM), 32'h0);

        // SB 0x202 then LHU 0x202 back to back
        set_e(1'b0, 1'b1, 2'b00, 5'd0, 3'b000, 32'h202, 32'h000000AB, 32'h0);
        step();
        set_e(1'b1, 1'b0, 2'b01, 5'd12, 3'b101, 32'h202, 32'h0, 32'h0);
        dmem.DMemReady = 1'b1;
        #1;
        chk("sb_be",    32'(dmem.DMemBe),                32'h4);
        chk("sb_lane2", 32'(dmem.DMemWData[23:16]),      32'hAB);
        step(); nop_e();
        dmem.DMemRData = 32'hCDAB1234;
        #1;
        chk("lhu_req",  32'(dmem.DMemReq), 32'h1);
        chk("lhu_we",   32'(dmem.DMemWe),  32'h0);
        chk("lhu_data", ReadDataM,         32'h0000CDAB);
        step();
        dmem.DMemReady = 1'b0;
        #1;
        chk("lhu_single_req", 32'(dmem.DMemReq), 32'h0);

        // Randomized traffic with a random-latency memory
        pend = 1'b0;
        cnt  = 0;
        for (int c = 0; c < 500; c++) begin
            kind = $urandom_range(0, 3);
            alu  = $urandom;
            if ($urandom_range(0, 1) == 0) alu[1:0] = 2'b00;
            f3   = 3'($urandom);
            case (kind)
                1: begin
                    if ($urandom_range(0, 3) != 0) begin
                        case ($urandom_range(0, 4))
                            0: f3 = 3'd0;
                            1: f3 = 3'd1;
                            2: f3 = 3'd2;
                            3: f3 = 3'd4;
                            default: f3 = 3'd5;
                        endcase
                    end
                    set_e(1'($urandom), 1'b0, 2'b01, 5'($urandom), f3, alu, $urandom, $urandom);
                end
                2: set_e(1'($urandom), 1'b1, 2'b00, 5'($urandom), 3'($urandom_range(0, 3)),
                         alu, $urandom, $urandom);
                default: set_e(1'($urandom), 1'b0, ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10,
                               5'($urandom), f3, alu, $urandom, $urandom);
            endcase
            dmem.DMemRData = $urandom;
            if (dmem.DMemReq) begin
                if (!pend) begin
                    pend = 1'b1;
                    cnt  = $urandom_range(0, 3);
                end
                dmem.DMemReady = (cnt == 0);
                if (cnt == 0) pend = 1'b0;
                else          cnt--;
            end else begin
                pend = 1'b0;
                dmem.DMemReady = ($urandom_range(0, 7) == 0);
            end
            step();
        end
        nop_e();
        dmem.DMemReady = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 RegWriteE, MemWriteE  in  1 each  Execute control.
REQ-005 ResultSrcE  in  2  result select; 2'b01 = load.
REQ-006 RdE  in  5  destination register.
REQ-007 Funct3E  in  3  access width/sign.
REQ-008 ALUResultE, WriteDataE, PCPlus4E  in  32 each  Execute results.
REQ-009 RegWriteM  out  1;  ResultSrcM  out  2;  RdM  out  5  registered controls toward Writeback/Hazard Unit.
REQ-010 ALUResultM  out  32  registered address/result; forwarded to Execute.
REQ-011 PCPlus4M, ReadDataM  out  32 each  PC+4 and formatted load data.
REQ-012 BusyM  out  1  stall request to Hazard Unit.
REQ-013 MisalignM  out  1  current M-stage access is misaligned.
REQ-014 DMemReq, DMemWe  out  1 each  data-memory request, write enable.
REQ-015 DMemAddr  out  32  word address (ALUResultM with [1:0] forced to 0).
REQ-016 DMemWData  out  32;  DMemBe  out  4  lane-shifted store data, byte enables.
REQ-017 DMemRData  in  32;  DMemReady  in  1  read data and completion.

Function
REQ-018 SHALL hold an EX/MEM register capturing all E inputs on each rising clk when BusyM=0, and holding when BusyM=1.
REQ-019 MemOpM SHALL be MemWriteM or (ResultSrcM==2'b01).
REQ-020 FSM states SHALL be IDLE and WAIT.
REQ-021 IDLE: MemOpM=1 and aligned -> DMemReq=1; DMemReady=1 in the same cycle -> stay IDLE, BusyM=0; otherwise -> WAIT, BusyM=1.
REQ-022 WAIT: DMemReq, DMemWe, DMemAddr, DMemWData and DMemBe SHALL be held stable; BusyM = ~DMemReady; DMemReady=1 -> IDLE.
REQ-023 Zero-wait memory SHALL give 1-cycle M latency; each wait cycle SHALL add exactly 1 stall cycle.
REQ-024 Each instruction SHALL issue exactly one request, with no re-issue after completion.
REQ-025 Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0. On violation: MisalignM=1, no DMemReq, BusyM=0, ReadDataM=0, RegWriteM forced to 0.
REQ-026 Stores (SB/SH/SW): DMemBe = 0001/0011/1111 shifted left by addr[1:0]; data replicated onto the selected lanes.
REQ-027 Loads: ReadDataM SHALL be combinational from DMemRData in the ready cycle; LB/LH sign-extend, LBU/LHU zero-extend, byte lane selected by addr[1:0].
REQ-028 ReadDataM SHALL be 0 when the access is not a load or DMemReady=0.
REQ-029 Non-memory instructions SHALL pass through with BusyM=0 and DMemReq=0.
REQ-030 Unsupported Funct3 on a memory op SHALL be treated as misaligned (REQ-025).

Reset
REQ-031 rst SHALL asynchronously set all registered outputs to 0 and the FSM to IDLE; DMemReq SHALL drop immediately.
REQ-032 Reset during WAIT SHALL abandon the access; a late DMemReady SHALL be ignored.

Structure
REQ-033 Shared riscv_pkg SHALL hold the FSM state enum, the Funct3 load/store constants and the ResultSrc encodings.
REQ-034 Byte-lane formatting SHALL be a combinational sub-module load_store_align.

Verification
REQ-035 SW, addr 0x100, data 0xDEADBEEF, ready same cycle -> DMemBe=1111, DMemAddr=0x100, BusyM never 1.
REQ-036 LB, addr 0x103, DMemRData=0x80000000 -> ReadDataM=0xFFFFFF80; LBU same stimulus -> 0x00000080.
REQ-037 LW with ready delayed 3 cycles -> BusyM=1 for exactly 3 cycles, request stable, E inputs not captured until completion.
REQ-038 SH to 0x101 -> MisalignM=1, DMemReq=0, RegWriteM=0, pipeline advances the next cycle.
REQ-039 rst asserted in WAIT -> DMemReq=0 and state IDLE immediately; post-reset DMemReady=1 produces no capture.
REQ-040 Back-to-back SB 0x202 (0xAB) then LHU 0x202 -> DMemBe=0100, DMemWData[23:16]=0xAB; then a single LHU request.
